mp3_switch_ctrl: RTL
====================

// Module: mp3_switch_ctrl
// PURPOSE
//  Avalon-MM controller for the MP3 player's board switches; sits between raw pins and Nios II.
//  Synchronises and debounces each switch, latches qualifying edges in a W1C capture register.
//  Raises a maskable level IRQ so firmware reacts to play/pause/track changes without polling.
// PARAMETERS
//  WIDTH            3       number of switch inputs (1..32)
//  DEBOUNCE_CYCLES  500000  cycles an input must stay stable to be accepted (10 ms @ 50 MHz); >=2
//  CNT_W            19      debounce counter width; 2**CNT_W >= DEBOUNCE_CYCLES
//  EDGE_MODE        2       0 = rising only, 1 = falling only, 2 = both edges captured
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  in_port    in   WIDTH  raw switch pins, asynchronous to clk
//  address    in   2      word address: 0 DATA, 1 RAW, 2 IRQ_MASK, 3 EDGE_CAPTURE
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe, qualified by chipselect
//  writedata  in   32     write data; bits above WIDTH ignored
//  readdata   out  32     registered read data, zero-extended
//  irq        out  1      level interrupt to CPU
// BEHAVIOUR
//  Reset: sync flops, stable state, counters, IRQ_MASK, EDGE_CAPTURE, readdata, irq all 0.
//  Sync: two-flop synchroniser per bit; sync_q = 2nd stage.
//  Debounce, per bit, independent counters:
//   - sync_q == stable: counter <= 0.
//   - sync_q != stable: counter++; at DEBOUNCE_CYCLES-1 -> stable <= sync_q, counter <= 0.
//   - glitch shorter than DEBOUNCE_CYCLES restarts count; stable never changes.
//   - latency pin->stable: 2 sync cycles + DEBOUNCE_CYCLES cycles.
//  Edge detect on stable (prev vs current, one cycle): rise = ~prev & cur, fall = prev & ~cur.
//   qualifying edge per EDGE_MODE sets corresponding EDGE_CAPTURE bit (sticky).
//  Switch held high through reset: stable starts 0, so a rising edge is captured after
//   debounce following reset release (firmware clears at init).
//  Writes (chipselect & ~write_n), take effect next edge:
//   - addr 2: IRQ_MASK <= writedata[WIDTH-1:0].
//   - addr 3: EDGE_CAPTURE bits written 1 are cleared; 0 leaves bit unchanged.
//   - addr 0/1: ignored.
//   - same-cycle set and W1C of same bit: set wins (edge never lost).
//  Reads: readdata updated every cycle from address (1-cycle latency, no wait states):
//   0 -> stable, 1 -> sync_q, 2 -> IRQ_MASK, 3 -> EDGE_CAPTURE; bits [31:WIDTH] = 0.
//   reads have no side effects.
//  irq: registered, irq <= |(EDGE_CAPTURE & IRQ_MASK); asserts 1 cycle after capture bit sets;
//   deasserts 1 cycle after clear or mask write.
//  Reset mid-debounce: counters and state return to 0 immediately; in-flight edge discarded.
// TESTING (bench uses DEBOUNCE_CYCLES=4, EDGE_MODE=2, WIDTH=3)
//  in_port 000->001 held -> DATA reads 001 exactly 6 cycles after pin change; EDGE_CAPTURE=001.
//  in_port bit1 pulses high 3 cycles -> DATA stays 000, EDGE_CAPTURE unchanged, irq stays 0.
//  IRQ_MASK=001, bit0 rises -> irq=1 one cycle after capture; write 001 to addr 3 -> irq=0 next.
//  W1C of bit2 on same cycle bit2 edge captured -> EDGE_CAPTURE[2] remains 1, irq per mask.
//  EDGE_MODE=0 rerun: 001->000 captures nothing; 000->001 sets bit0.
//  reset_n low while bit0 mid-count -> all outputs 0 asynchronously; pin held -> re-debounced after.

Source files
------------

// File: rtl/mp3_switch_ctrl_if.sv
// Avalon-MM slave bus for the switch controller. The CPU side drives the
// request fields, and the controller returns read data and the interrupt.
interface mp3_switch_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/mp3_switch_ctrl.sv
// MP3 player switch controller. Each switch pin is synchronised and debounced,
// and qualifying edges are latched into a W1C capture register. The block
// raises a maskable level interrupt toward the Nios II.

// Per-switch lane: two-flop synchroniser followed by a stability counter.
module mp3_switch_db #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync_q,
  output logic stable
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise the pin. Accept a new level only after it has differed from
  // 'stable' for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_d <= pin;
      sync_q <= sync_d;
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module mp3_switch_ctrl #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int EDGE_MODE       = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    in_port,
  mp3_switch_ctrl_if.slave    bus
);
  logic [WIDTH-1:0] sync_q, stable, prev_q;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [WIDTH-1:0] rise, fall, edge_hit, clr;
  logic             wr_en;
  logic             unused_wdata;

  // One debounce lane per switch.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mp3_switch_db #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .sync_q  (sync_q[i]),
      .stable  (stable[i])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign clr          = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign rise         = ~prev_q & stable;
  assign fall         = prev_q & ~stable;
  assign unused_wdata = ^bus.writedata;

  // Select which debounced transitions are captured.
  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
  end

  // Edge history, mask register, and sticky capture. A new edge overrides a
  // same-cycle W1C so firmware never loses one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      prev_q   <= stable;
      edge_cap <= (edge_cap & ~clr) | edge_hit;
      if (wr_en && bus.address == 2'd2)
        irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  // Registered read mux with no side effects, plus the registered level IRQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      case (bus.address)
        2'd0:    bus.readdata <= 32'(stable);
        2'd1:    bus.readdata <= 32'(sync_q);
        2'd2:    bus.readdata <= 32'(irq_mask);
        default: bus.readdata <= 32'(edge_cap);
      endcase
      bus.irq <= |(edge_cap & irq_mask);
    end
  end
endmodule
